// File: rtl/apb_slave_responder.sv
// APB completer: byte-strobed register file, programmable wait states, transfer counter.
// Define APB_SLAVE_RESPONDER_ERR_EN to flag out-of-range word indices with pslverr.
module apb_slave_responder #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                      pclk,
    input  logic                      preset,
    input  logic                      psel,
    input  logic                      penable,
    input  logic                      pwrite,
    input  logic [ADDR_WIDTH-1:0]     paddr,
    input  logic [DATA_WIDTH-1:0]     pwdata,
    input  logic [DATA_WIDTH/8-1:0]   pstrb,
    output logic [DATA_WIDTH-1:0]     prdata,
    output logic                      pready,
    output logic                      pslverr,
    output logic [15:0]               xfer_count
);

    localparam int BYTES = DATA_WIDTH / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_e;

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   prdata_q;
    logic                    err_q;
    logic [15:0]             xfer_q;
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic [ADDR_WIDTH-1:0]   word_full;
    logic [IW-1:0]           idx;
    logic                    addr_err;
    logic                    done;
    logic                    wr_en;

    assign word_full = paddr >> OFF;
    assign idx       = word_full[IW-1:0];

`ifdef APB_SLAVE_RESPONDER_ERR_EN
    assign addr_err = (word_full >> IW) != '0;
`else
    // Out-of-range indices alias onto the register file.
    logic unused_word;
    assign addr_err    = 1'b0;
    assign unused_word = ^word_full;
`endif

    assign done  = (state_q == S_RESP) && psel && penable;
    assign wr_en = done && pwrite && !addr_err;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (psel && !penable) begin
                    cnt_d = 4'(WAIT_CYCLES);
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!psel) begin
                    state_d = S_IDLE;
                end else if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prdata_q <= '0;
            err_q    <= 1'b0;
            xfer_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_d == S_RESP) begin
                prdata_q <= (!pwrite && !addr_err) ? mem_q[idx] : '0;
                err_q    <= addr_err;
            end
            if (done) begin
                xfer_q <= xfer_q + 16'd1;
            end
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (pstrb[b]) begin
                    mem_q[idx][b*8 +: 8] <= pwdata[b*8 +: 8];
                end
            end
        end
    end

    assign pready     = (state_q == S_RESP);
    assign pslverr    = (state_q == S_RESP) && err_q;
    assign prdata     = prdata_q;
    assign xfer_count = xfer_q;

endmodule

// File: doc/apb_slave_responder.md
# apb_slave_responder

Synthesizable APB slave that sits directly downstream of the master driver BFM on `p_if` and answers every transfer the driver produces. It holds a small byte-strobed register file, inserts a programmable number of wait states, and returns read data and error status. The HDL top uses it as the default completer, so master-side sequences run end to end without a slave BFM.

## Interface
Parameters:
- `ADDR_WIDTH`, 8: width of `paddr`, in byte address bits.
- `DATA_WIDTH`, 32: width of `pwdata`/`prdata`; must be 8, 16 or 32.
- `DEPTH`, 16: number of register words; must be a power of two and ≤ 2^(ADDR_WIDTH − log2(DATA_WIDTH/8)).
- `WAIT_CYCLES`, 2: wait states inserted before `pready`; range 0–15.

Ports:
- `pclk`  in  1  clock; all logic on the rising edge.
- `preset`  in  1  synchronous, active-high reset.
- `psel`  in  1  slave select.
- `penable`  in  1  access phase.
- `pwrite`  in  1  1 = write, 0 = read.
- `paddr`  in  ADDR_WIDTH  byte address.
- `pwdata`  in  DATA_WIDTH  write data.
- `pstrb`  in  DATA_WIDTH/8  write byte enables.
- `prdata`  out  DATA_WIDTH  read data, valid while `pready` = 1.
- `pready`  out  1  transfer completes this cycle.
- `pslverr`  out  1  error, valid while `pready` = 1.
- `xfer_count`  out  16  number of completed transfers.

## Operation
- Word index: `paddr >> log2(DATA_WIDTH/8)`. Low address bits are ignored.
- FSM states:
  - IDLE → WAIT when `psel`=1 and `penable`=0. On this transition the wait counter loads `WAIT_CYCLES`.
  - IDLE → RESP directly if `WAIT_CYCLES`=0.
  - WAIT: the counter decrements each cycle. When the counter is 1, go to RESP.
  - WAIT → IDLE if `psel`=0 (abort). Aborts cause no write and no count.
  - RESP → IDLE unconditionally. RESP lasts exactly one cycle.
- Outputs by state:
  - `pready` = 1 only in RESP (registered state decode).
  - `prdata` is loaded on the edge entering RESP: memory word for reads, 0 for writes.
  - `prdata` holds its value otherwise.
- Writes:
  - Committed on the edge ending RESP, only when `psel`=1, `penable`=1 and `pwrite`=1.
  - Byte lane i is updated only when `pstrb[i]`=1.
- Count: `xfer_count` increments on the edge ending RESP when `psel`=1 and `penable`=1. It wraps from 0xFFFF to 0x0000.
- Back-to-back transfers: a new setup phase is accepted in the cycle after RESP, from IDLE.
- `penable` = 1 observed in IDLE (protocol violation) is ignored; the FSM stays in IDLE.

## Timing
- Reset values: state IDLE, `pready` 0, `pslverr` 0, `prdata` 0, `xfer_count` 0, all register words 0.
- Reset asserted mid-transfer aborts it: no write is performed and no count is taken.
- Setup phase in cycle T: `pready` = 1 in cycle T+1+`WAIT_CYCLES`.
- Transfer length from setup to completion: 2+`WAIT_CYCLES` cycles.
- Read-after-write to the same word in the next transfer returns the new data.
- Address, data and strobe are sampled on the edge entering RESP (reads) or ending RESP (writes). The master must hold them stable per APB.

## Configuration
- `APB_SLAVE_RESPONDER_ERR_EN` defined:
  - A word index ≥ `DEPTH` drives `pslverr`=1 during RESP.
  - The write is suppressed and `prdata` = 0.
  - `xfer_count` still increments.
- Not defined:
  - `pslverr` is tied to 0.
  - The word index is taken modulo `DEPTH` (out-of-range addresses alias).

## Test plan
- Reset, then idle 5 cycles → `pready`=0, `pslverr`=0, `prdata`=0, `xfer_count`=0.
- `WAIT_CYCLES`=2: write 0xDEADBEEF to 0x04 with `pstrb`=0xF, then read 0x04 → each `pready` pulse appears 3 cycles after setup; read returns 0xDEADBEEF; `xfer_count`=2.
- Write 0x11223344 to 0x08 with `pstrb`=0xF, then write 0xAABBCCDD with `pstrb`=0x5, then read → 0x11BB33DD.
- `psel` dropped during WAIT → no `pready`, memory unchanged, `xfer_count` unchanged; a following read completes normally.
- `preset` asserted in WAIT of a write → outputs return to reset values; a read of that address returns 0.
- With `ERR_EN`, write to 0x40 (index 16, `DEPTH`=16) → `pslverr`=1 with `pready`; a read of 0x00 returns 0. Without the macro, the same write aliases to index 0 and a read of 0x00 returns the written data.
